// File: rtl/pll_mon_pkg.sv
// Shared types and defaults for the PLL lock monitor.
package pll_mon_pkg;

  typedef enum logic [1:0] {IDLE, ARM, ACQUIRE, LOCKED} pll_mon_state_e;

  localparam int REF_WIN_DEF     = 16;
  localparam int CNT_W_DEF       = 12;
  localparam int TOL_DEF         = 4;
  localparam int LOCK_WINS_DEF   = 4;
  localparam int UNLOCK_WINS_DEF = 2;

  localparam logic [3:0] MULT_INVALID = 4'd0;

endpackage

// File: rtl/ref_edge_sync.sv
// Two-flop synchronizer plus edge flop; pulses rise for one clk cycle per
// rising edge of an asynchronous input.
module ref_edge_sync (
  input  logic clk,
  input  logic porb,
  input  logic async_in,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (!porb) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/pll_lock_monitor.sv
// Counts clk cycles over REF_WIN reference periods and judges PLL lock
// against mult*REF_WIN, with sticky loss-of-lock / loss-of-reference flags.
module pll_lock_monitor
  import pll_mon_pkg::*;
#(
  parameter int REF_WIN     = REF_WIN_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TOL         = TOL_DEF,
  parameter int LOCK_WINS   = LOCK_WINS_DEF,
  parameter int UNLOCK_WINS = UNLOCK_WINS_DEF
) (
  input  logic             clk,
  input  logic             porb,
  input  logic             ref_clk,
  input  logic             en,
  input  logic [3:0]       mult,
  output logic             locked,
  output logic [CNT_W-1:0] meas_cnt,
  output logic             meas_valid,
  output logic             unlock_err,
  output logic             ref_lost,
  output logic             cfg_err
);

  localparam int EDGE_W = $clog2(REF_WIN + 1);
  localparam int RUN_MAX = (LOCK_WINS > UNLOCK_WINS) ? LOCK_WINS : UNLOCK_WINS;
  localparam int RUN_W = $clog2(RUN_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(REF_WIN - 1);

  logic ref_rise;

  ref_edge_sync u_ref_sync (
    .clk      (clk),
    .porb     (porb),
    .async_in (ref_clk),
    .rise     (ref_rise)
  );

  pll_mon_state_e     state;
  logic               en_q;
  logic               win_open;
  logic               win_sat;
  logic [3:0]         mult_q;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic [CNT_W-1:0]   expected;
  logic [EDGE_W-1:0]  edge_cnt;
  logic [RUN_W-1:0]   good_run;
  logic [RUN_W-1:0]   bad_run;
  logic signed [CNT_W:0] diff;
  logic [CNT_W:0]     abs_diff;
  logic               win_good;
  logic               win_close;

  assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign win_close = win_open && ref_rise && (edge_cnt == LAST_EDGE);
  assign expected  = CNT_W'(mult_q) * CNT_W'(REF_WIN);

  // Scoring happens on the meas_valid cycle, using the registered window result.
  assign diff     = $signed({1'b0, meas_cnt}) - $signed({1'b0, expected});
  assign abs_diff = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
  assign win_good = !win_sat && (abs_diff <= (CNT_W+1)'(TOL));

  always_ff @(posedge clk) begin
    if (!porb) begin
      state      <= IDLE;
      en_q       <= 1'b0;
      win_open   <= 1'b0;
      win_sat    <= 1'b0;
      mult_q     <= '0;
      cnt        <= '0;
      edge_cnt   <= '0;
      good_run   <= '0;
      bad_run    <= '0;
      locked     <= 1'b0;
      meas_cnt   <= '0;
      meas_valid <= 1'b0;
      unlock_err <= 1'b0;
      ref_lost   <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      en_q       <= en;
      meas_valid <= 1'b0;
      if (en && !en_q) begin
        unlock_err <= 1'b0;
        ref_lost   <= 1'b0;
        cfg_err    <= 1'b0;
      end
      if (!en) begin
        state    <= IDLE;
        win_open <= 1'b0;
        cnt      <= '0;
        edge_cnt <= '0;
        good_run <= '0;
        bad_run  <= '0;
        locked   <= 1'b0;
      end else begin
        if (win_open) begin
          if (win_close) begin
            meas_cnt   <= cnt_inc;
            win_sat    <= (cnt_inc == CNT_MAX);
            meas_valid <= 1'b1;
            cnt        <= '0;
            edge_cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
            if (ref_rise) edge_cnt <= edge_cnt + 1'b1;
          end
        end

        case (state)
          IDLE: begin
            if (mult == MULT_INVALID) begin
              cfg_err <= 1'b1;
            end else begin
              mult_q <= mult;
              state  <= ARM;
            end
          end
          ARM: begin
            if (ref_rise) begin
              win_open <= 1'b1;
              cnt      <= '0;
              edge_cnt <= '0;
              state    <= ACQUIRE;
            end
          end
          ACQUIRE: begin
            if (!win_open) begin
              if (ref_rise) begin
                win_open <= 1'b1;
                cnt      <= '0;
                edge_cnt <= '0;
              end
            end else if (meas_valid) begin
              if (win_good) begin
                if (good_run == RUN_W'(LOCK_WINS - 1)) begin
                  state    <= LOCKED;
                  locked   <= 1'b1;
                  good_run <= '0;
                  bad_run  <= '0;
                end else begin
                  good_run <= good_run + 1'b1;
                end
              end else begin
                good_run <= '0;
              end
            end
          end
          LOCKED: begin
            if (meas_valid) begin
              if (!win_good) begin
                if (bad_run == RUN_W'(UNLOCK_WINS - 1)) begin
                  state      <= ACQUIRE;
                  locked     <= 1'b0;
                  unlock_err <= 1'b1;
                  bad_run    <= '0;
                  good_run   <= '0;
                end else begin
                  bad_run <= bad_run + 1'b1;
                end
              end else begin
                bad_run <= '0;
              end
            end
          end
          default: state <= IDLE;
        endcase

        // A full counter with no edge means the reference has gone away.
        if (win_open && (cnt == CNT_MAX) && !ref_rise) begin
          ref_lost <= 1'b1;
          locked   <= 1'b0;
          state    <= ACQUIRE;
          win_open <= 1'b0;
          cnt      <= '0;
          edge_cnt <= '0;
          good_run <= '0;
          bad_run  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed bench for pll_lock_monitor: reference edges on an absolute time grid,
// window results scored through a queue and checked when meas_valid pulses.
module tb_pll_lock_monitor;

  localparam int REF_WIN = 16;
  localparam int TOL     = 4;
  localparam int HIGH_T  = 20;

  logic        clk = 1'b0;
  logic        porb;
  logic        ref_clk;
  logic        en;
  logic [3:0]  mult;
  logic        locked;
  logic [11:0] meas_cnt;
  logic        meas_valid;
  logic        unlock_err;
  logic        ref_lost;
  logic        cfg_err;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [11:0] cnt;
    logic        lk;
  } exp_t;
  exp_t sb[$];

  logic m_locked;
  logic m_unlock;
  int   m_good;
  int   m_bad;
  int   cur_mult;
  time  next_rise;

  always #5 clk = ~clk;

  pll_lock_monitor dut (
    .clk        (clk),
    .porb       (porb),
    .ref_clk    (ref_clk),
    .en         (en),
    .mult       (mult),
    .locked     (locked),
    .meas_cnt   (meas_cnt),
    .meas_valid (meas_valid),
    .unlock_err (unlock_err),
    .ref_lost   (ref_lost),
    .cfg_err    (cfg_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void modelReset();
    m_locked = 1'b0;
    m_unlock = 1'b0;
    m_good   = 0;
    m_bad    = 0;
  endfunction

  // Reference model of one window's result and the lock decision it causes.
  task automatic scoreWindow(input int ratio);
    int  c;
    int  d;
    bit  good;
    exp_t e;
    c    = REF_WIN * ratio;
    d    = c - REF_WIN * cur_mult;
    good = (d <= TOL) && (d >= -TOL);
    if (!m_locked) begin
      if (good) begin
        m_good++;
        if (m_good == 4) begin
          m_locked = 1'b1;
          m_good   = 0;
          m_bad    = 0;
        end
      end else begin
        m_good = 0;
      end
    end else begin
      if (!good) begin
        m_bad++;
        if (m_bad == 2) begin
          m_locked = 1'b0;
          m_unlock = 1'b1;
          m_bad    = 0;
          m_good   = 0;
        end
      end else begin
        m_bad = 0;
      end
    end
    e.cnt = 12'(c);
    e.lk  = m_locked;
    sb.push_back(e);
  endtask

  task automatic refEdge(input int ratio);
    next_rise += time'(ratio * 10);
    #(next_rise - $time) ref_clk = 1'b1;
    #(HIGH_T) ref_clk = 1'b0;
  endtask

  task automatic applyStimulus(input int ratio, input int nwin, input bit open_edge);
    if (open_edge) begin
      next_rise = $time;
      refEdge(ratio);
    end
    for (int w = 0; w < nwin; w++) begin
      scoreWindow(ratio);
      for (int e = 0; e < REF_WIN; e++) refEdge(ratio);
    end
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (meas_valid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_valid", meas_valid, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("meas_cnt", meas_cnt, e.cnt);
        @(negedge clk);
        checkOutput("locked_after_window", locked, e.lk);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    porb = 1'b0; en = 1'b0; mult = 4'd8; ref_clk = 1'b0;
    cur_mult = 8; next_rise = 0;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("rst_locked", locked, 0);
    checkOutput("rst_meas_cnt", meas_cnt, 0);
    checkOutput("rst_meas_valid", meas_valid, 0);
    checkOutput("rst_unlock_err", unlock_err, 0);
    checkOutput("rst_ref_lost", ref_lost, 0);
    checkOutput("rst_cfg_err", cfg_err, 0);
    porb = 1'b1;

    $display("[TB] invalid mult");
    mult = 4'd0; en = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("cfg_err_set", cfg_err, 1);
    next_rise = $time;
    for (int i = 0; i < 40; i++) refEdge(8);
    settle();
    checkOutput("cfg_err_hold", cfg_err, 1);
    checkOutput("cfg_locked", locked, 0);
    en = 1'b0;
    @(negedge clk);
    mult = 4'd8; en = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("cfg_err_clr", cfg_err, 0);

    $display("[TB] lock at 8x");
    applyStimulus(8, 4, 1'b1);
    settle();
    checkOutput("lock_locked", locked, 1);
    checkOutput("lock_unlock_err", unlock_err, 0);
    checkOutput("lock_ref_lost", ref_lost, 0);
    checkOutput("lock_cfg_err", cfg_err, 0);

    $display("[TB] ratio step to 10 and back");
    applyStimulus(10, 2, 1'b0);
    settle();
    checkOutput("step_locked", locked, m_locked);
    checkOutput("step_unlock_err", unlock_err, m_unlock);
    applyStimulus(8, 4, 1'b0);
    settle();
    checkOutput("relock_locked", locked, 1);
    checkOutput("relock_unlock_err", unlock_err, 1);

    $display("[TB] reference stops");
    repeat (3900) @(negedge clk);
    checkOutput("refstop_early_lost", ref_lost, 0);
    checkOutput("refstop_early_locked", locked, 1);
    repeat (300) @(negedge clk);
    checkOutput("refstop_lost", ref_lost, 1);
    checkOutput("refstop_locked", locked, 0);
    m_locked = 1'b0; m_good = 0; m_bad = 0;
    applyStimulus(8, 4, 1'b1);
    settle();
    checkOutput("refback_locked", locked, 1);
    checkOutput("refback_lost_sticky", ref_lost, 1);

    $display("[TB] re-enable, ratio 9");
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    repeat (3) @(negedge clk);
    modelReset();
    checkOutput("reen_unlock_err", unlock_err, 0);
    checkOutput("reen_ref_lost", ref_lost, 0);
    checkOutput("reen_locked", locked, 0);
    applyStimulus(9, 3, 1'b1);
    settle();
    checkOutput("ratio9_locked", locked, 0);

    $display("[TB] reset mid-window");
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    repeat (3) @(negedge clk);
    modelReset();
    applyStimulus(8, 2, 1'b0 == 1'b1 ? 1'b0 : 1'b1);
    for (int i = 0; i < 8; i++) refEdge(8);
    @(negedge clk);
    porb = 1'b0;
    @(negedge clk);
    checkOutput("porb_locked", locked, 0);
    checkOutput("porb_meas_cnt", meas_cnt, 0);
    checkOutput("porb_meas_valid", meas_valid, 0);
    checkOutput("porb_unlock_err", unlock_err, 0);
    checkOutput("porb_ref_lost", ref_lost, 0);
    checkOutput("porb_cfg_err", cfg_err, 0);
    porb = 1'b1;
    modelReset();
    repeat (3) @(negedge clk);
    applyStimulus(8, 4, 1'b1);
    settle();
    checkOutput("porb_relock", locked, 1);

    repeat (5) @(negedge clk);
    checkOutput("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
